// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback,
// drives ALU control and memory strobes, and counts retired instructions.
module multicycle_control #(
    parameter int          CNT_W    = 16,
    parameter logic [5:0]  OP_RTYPE = 6'b000000,
    parameter logic [5:0]  OP_LW    = 6'b100011,
    parameter logic [5:0]  OP_SW    = 6'b101011,
    parameter logic [5:0]  OP_BEQ   = 6'b000100,
    parameter logic [5:0]  FN_ADD   = 6'b100000,
    parameter logic [5:0]  FN_SUB   = 6'b100010
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [1:0]       alucontrol,
    output logic             alusrc,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             busy,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_BRANCH = 3'd6;

    localparam logic [1:0] ALU_SUB = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_CMP = 2'b10;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [5:0]       op_q;
    logic [5:0]       fn_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    function automatic logic is_alu_rtype(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_RTYPE) && ((fn == FN_ADD) || (fn == FN_SUB));
    endfunction

    function automatic logic goes_to_exec(input logic [5:0] op, input logic [5:0] fn);
        return is_alu_rtype(op, fn) || (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic [2:0] boundary_next(input logic run_i);
        return run_i ? S_FETCH : S_IDLE;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            retired_q <= '0;
        end else begin
            state <= state_nxt;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // The IR is valid during DECODE; later states decode from this copy.
    always_ff @(posedge clk) begin
        if (state == S_DECODE) begin
            op_q <= opcode;
            fn_q <= funct;
        end
    end

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (run) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_ready) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (goes_to_exec(opcode, funct)) begin
                    state_nxt = S_EXEC;
                end else if (opcode == OP_BEQ) begin
                    state_nxt = S_BRANCH;
                end else begin
                    state_nxt = boundary_next(run);
                end
            end
            S_EXEC: begin
                state_nxt = (op_q == OP_RTYPE) ? S_WB : S_MEM;
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_nxt = S_WB;
                    end else begin
                        retire    = 1'b1;
                        state_nxt = boundary_next(run);
                    end
                end
            end
            S_WB, S_BRANCH: begin
                retire    = 1'b1;
                state_nxt = boundary_next(run);
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alucontrol = ALU_SUB;
        alusrc     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        illegal    = 1'b0;
        busy       = (state != S_IDLE);
        unique case (state)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: begin
                illegal = !goes_to_exec(opcode, funct) && (opcode != OP_BEQ);
            end
            S_EXEC: begin
                if (op_q == OP_RTYPE) begin
                    alucontrol = (fn_q == FN_SUB) ? ALU_SUB : ALU_ADD;
                end else begin
                    alusrc     = 1'b1;
                    alucontrol = ALU_ADD;
                end
            end
            S_MEM: begin
                alusrc     = 1'b1;
                alucontrol = ALU_ADD;
                mem_read   = (op_q == OP_LW);
                mem_write  = (op_q == OP_SW);
            end
            S_WB: begin
                reg_write = 1'b1;
                if (op_q == OP_LW) begin
                    mem_to_reg = 1'b1;
                end else begin
                    reg_dst = 1'b1;
                end
            end
            S_BRANCH: begin
                // zero is only meaningful while the ALU is in compare mode.
                alucontrol = ALU_CMP;
                pc_write   = zero;
                pc_src     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign retired = retired_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM that drives the datapath, including the existing ALU's alucontrol/alusrc inputs, and consumes the ALU's zero flag.
- Sequences each instruction through fetch, decode, execute, memory and writeback, with a memory-ready handshake and a retired-instruction counter.
- Replaces the purely combinational decode of the single-cycle core when the team moves to the multi-cycle processor.

Parameters:
CNT_W, 16, width of retired-instruction counter
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load-word opcode
OP_SW, 6'b101011, store-word opcode
OP_BEQ, 6'b000100, branch-if-equal opcode
FN_ADD, 6'b100000, R-type add funct
FN_SUB, 6'b100010, R-type sub funct

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  start/continue execution
opcode  in  6  instruction[31:26] from external IR
funct  in  6  instruction[5:0] from external IR
zero  in  1  ALU equality flag, valid only while alucontrol=10
mem_ready  in  1  memory access completes this cycle
ir_write  out  1  load IR
pc_write  out  1  update PC
pc_src  out  1  0 = PC+4, 1 = external branch target
alucontrol  out  2  00 = sub, 01 = add, 10 = compare
alusrc  out  1  0 = register b, 1 = immediate r
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
reg_write  out  1  register-file write enable
mem_to_reg  out  1  writeback source: 1 = memory, 0 = ALU
reg_dst  out  1  1 = rd, 0 = rt
busy  out  1  FSM not in IDLE
illegal  out  1  one-cycle pulse on undecodable instruction
retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE immediately.
  - Every output is 0 and retired=0 immediately.
  - Any strobe mid-instruction drops without waiting for clk.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, BRANCH.
- Outputs are decoded from the current state and the latched opcode/funct. The only combinational input paths are mem_ready and zero, as listed below.
- Default in every state: all outputs 0 except busy.
- IDLE:
  - busy=0.
  - run=1 -> FETCH.
- FETCH:
  - mem_read=1.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, and next state DECODE.
  - When mem_ready=0: stay in FETCH with no IR or PC writes.
- DECODE:
  - Latch opcode and funct internally.
  - R-type with funct in {FN_ADD, FN_SUB}, OP_LW or OP_SW -> EXEC.
  - OP_BEQ -> BRANCH.
  - Anything else -> illegal=1 for this cycle, no retire, next state FETCH (or IDLE if run=0).
- EXEC:
  - R-type: alusrc=0; alucontrol=01 for add, 00 for sub; next state WB.
  - lw/sw: alusrc=1, alucontrol=01; next state MEM.
- MEM:
  - lw: mem_read=1. sw: mem_write=1.
  - alusrc=1 and alucontrol=01 are held so the address stays stable.
  - Stall while mem_ready=0.
  - On mem_ready=1: lw -> WB; sw retires -> FETCH (or IDLE if run=0).
- WB:
  - reg_write=1.
  - R-type: reg_dst=1, mem_to_reg=0.
  - lw: reg_dst=0, mem_to_reg=1.
  - Retire, then next state FETCH (or IDLE if run=0).
- BRANCH:
  - alucontrol=10, alusrc=0.
  - pc_write = zero and pc_src=1, combinational in this cycle.
  - Retire, then next state FETCH (or IDLE if run=0).
- Latency with mem_ready tied to 1, FETCH to retire inclusive: R-type 4 cycles, lw 5, sw 4, beq 3. Each mem_ready=0 cycle adds 1.
- retired:
  - Increments by 1 on the clock edge leaving a retiring state.
  - Wraps modulo 2^CNT_W.
  - Illegal instructions never count.
- run:
  - Sampled only at instruction boundaries (IDLE and retire/illegal exits).
  - Deasserting run mid-instruction lets that instruction complete, then the FSM enters IDLE.
- zero is ignored in every state except BRANCH, because the ALU leaves zero stale outside compare mode.
- illegal is never asserted together with any write strobe.

Test Plan:
- Reset, run=1, add (opcode 0, funct 0x20), mem_ready=1 -> FETCH/DECODE/EXEC(alucontrol=01, alusrc=0)/WB(reg_write=1, reg_dst=1); retired 0->1 after exactly 4 cycles.
- lw with mem_ready held low 3 cycles in MEM -> mem_read stays 1 for 4 MEM cycles, alusrc=1 and alucontrol=01 stable throughout; WB has mem_to_reg=1, reg_dst=0; total 8 cycles.
- beq with zero=1, then beq with zero=0 -> first gives pc_write=1 and pc_src=1 in BRANCH; second gives pc_write=0; retired advances by 2.
- Opcode 6'b111111, then R-type with funct 0x25 -> illegal pulses exactly 1 cycle in DECODE each time; no reg_write, mem_write or pc_write is asserted; retired unchanged.
- rst_n dropped mid-MEM of sw while mem_write=1 -> mem_write falls without a clock edge; state IDLE, retired=0, busy=0; resumes from FETCH only after run=1.
- CNT_W=4, 16 back-to-back sw, then run=0 during the 17th -> retired wraps 15->0 then reads 1; FSM enters IDLE after the 17th retires; busy=0.
